// File: rtl/smart_house_pkg.sv
// Shared constants and state encoding for the smart-house command parser.
package smart_house_pkg;
  localparam int TEMP_W = 32;

  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_M_LC  = 8'h6D;
  localparam logic [7:0] CH_L_LC  = 8'h6C;
  localparam logic [7:0] CH_C_LC  = 8'h63;
  localparam logic [7:0] CH_T_LC  = 8'h74;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  typedef enum logic [2:0] {IDLE, T_SIGN, T_DIGIT, COMMIT, FLUSH} state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR);
  endfunction
endpackage

// File: rtl/smart_house_cmd_parser_if.sv
// Byte-stream valid/ready channel into the parser.
interface smart_house_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/smart_house_cmd_parser_dec_accumulator.sv
// Decimal accumulator: acc = acc*10 + d, with a digit counter.
module dec_accumulator
  import smart_house_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [3:0]        digit,
  output logic [TEMP_W-1:0] acc,
  output logic [3:0]        count
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= TEMP_W'(digit);
      count <= 4'd1;
    end else if (step) begin
      // x10 as shift-and-add; at most 9 digits so no overflow
      acc   <= (acc << 3) + (acc << 1) + TEMP_W'(digit);
      count <= count + 4'd1;
    end
  end
endmodule

// File: rtl/smart_house_cmd_parser.sv
// ASCII command parser producing toggle pulses and a signed temperature request.
module smart_house_cmd_parser
  import smart_house_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int TEMP_DEFAULT = 25
) (
  input  logic                     clock,
  input  logic                     reset,
  smart_house_cmd_parser_if.slave  rx,
  output logic                     music_req,
  output logic                     light_req,
  output logic                     curtain_req,
  output logic signed [TEMP_W-1:0] temp_req,
  output logic                     temp_valid,
  output logic [7:0]               char_req,
  output logic                     err
);
  localparam logic [3:0]               MAX_CNT  = 4'(MAX_DIGITS);
  localparam logic signed [TEMP_W-1:0] TEMP_RST = TEMP_W'(TEMP_DEFAULT);

  state_t            state;
  logic              sign;
  logic [TEMP_W-1:0] acc;
  logic [3:0]        count;
  logic              take, dig, term, full;
  logic              is_m, is_l, is_c, is_t;
  logic              acc_clear, acc_load, acc_step;

  // Ready is gated by the reset pin so it reads 0 throughout reset
  assign rx.rx_ready = reset && (state != COMMIT);
  assign take        = rx.rx_valid && rx.rx_ready;

  assign dig  = is_digit(rx.rx_data);
  assign term = is_term(rx.rx_data);
  assign is_m = (rx.rx_data == CH_M) || (rx.rx_data == CH_M_LC);
  assign is_l = (rx.rx_data == CH_L) || (rx.rx_data == CH_L_LC);
  assign is_c = (rx.rx_data == CH_C) || (rx.rx_data == CH_C_LC);
  assign is_t = (rx.rx_data == CH_T) || (rx.rx_data == CH_T_LC);
  assign full = (count == MAX_CNT);

  assign acc_clear = take && (state == IDLE) && is_t;
  assign acc_load  = take && (state == T_SIGN) && dig;
  assign acc_step  = take && (state == T_DIGIT) && dig && !full;

  dec_accumulator u_acc (
    .clock (clock),
    .reset (reset),
    .clear (acc_clear),
    .load  (acc_load),
    .step  (acc_step),
    .digit (rx.rx_data[3:0]),
    .acc   (acc),
    .count (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sign        <= 1'b0;
      music_req   <= 1'b0;
      light_req   <= 1'b0;
      curtain_req <= 1'b0;
      temp_valid  <= 1'b0;
      err         <= 1'b0;
      temp_req    <= TEMP_RST;
      char_req    <= 8'h00;
    end else begin
      music_req   <= 1'b0;
      light_req   <= 1'b0;
      curtain_req <= 1'b0;
      temp_valid  <= 1'b0;
      err         <= 1'b0;
      if (state == COMMIT) begin
        temp_req   <= sign ? $signed(-acc) : $signed(acc);
        temp_valid <= 1'b1;
        state      <= IDLE;
      end else if (take) begin
        char_req <= rx.rx_data;
        case (state)
          IDLE: begin
            if (is_m)      music_req   <= 1'b1;
            else if (is_l) light_req   <= 1'b1;
            else if (is_c) curtain_req <= 1'b1;
            else if (is_t) begin
              sign  <= 1'b0;
              state <= T_SIGN;
            end else if (!(term || rx.rx_data == CH_SPACE)) err <= 1'b1;
          end
          T_SIGN: begin
            if (rx.rx_data == CH_MINUS) begin
              sign  <= 1'b1;
              state <= T_DIGIT;
            end else if (dig) state <= T_DIGIT;
            else begin
              err   <= 1'b1;
              state <= term ? IDLE : FLUSH;
            end
          end
          T_DIGIT: begin
            if (dig) begin
              if (full) begin
                err   <= 1'b1;
                state <= FLUSH;
              end
            end else if (term) begin
              if (count != 4'd0) state <= COMMIT;
              else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end else begin
              err   <= 1'b1;
              state <= FLUSH;
            end
          end
          FLUSH:   if (term) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_smart_house_cmd_parser.sv
// Scoreboard bench: string-level reference model queues expected events, monitor pops them.
module tb_smart_house_cmd_parser;
  localparam int MAXD = 4;

  logic               clock, reset;
  logic               music_req, light_req, curtain_req, temp_valid, err;
  logic signed [31:0] temp_req;
  logic [7:0]         char_req;

  smart_house_cmd_parser_if rx();

  smart_house_cmd_parser #(.MAX_DIGITS(MAXD), .TEMP_DEFAULT(25)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .music_req   (music_req),
    .light_req   (light_req),
    .curtain_req (curtain_req),
    .temp_req    (temp_req),
    .temp_valid  (temp_valid),
    .char_req    (char_req),
    .err         (err)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [7:0] kind; logic [31:0] val; } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the text of an open T command and judges it as a string
  bit          m_in_t, m_flush;
  logic [7:0]  tbuf[$];
  logic [31:0] model_temp = 32'd25;

  function automatic void push_ev(input logic [7:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // -1 if text is not a legal prefix of "[-]digits", otherwise number of digits
  function automatic int digits_of(input logic [7:0] q[$]);
    int n = 0;
    foreach (q[i]) begin
      if (i == 0 && q[i] == 8'h2D) continue;
      if (q[i] < 8'h30 || q[i] > 8'h39) return -1;
      n++;
    end
    return (n > MAXD) ? -1 : n;
  endfunction

  function automatic void model_reset();
    m_in_t = 0;
    m_flush = 0;
    tbuf.delete();
    model_temp = 32'd25;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] u;
    bit t;
    int v;
    t = (b == 8'h0A) || (b == 8'h0D);
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    if (m_flush) begin
      if (t) m_flush = 0;
      return;
    end
    if (!m_in_t) begin
      if (u == 8'h4D || u == 8'h4C || u == 8'h43) push_ev(u, 0);
      else if (u == 8'h54) begin m_in_t = 1; tbuf.delete(); end
      else if (!(t || b == 8'h20)) push_ev("E", 0);
      return;
    end
    if (t) begin
      if (digits_of(tbuf) >= 1) begin
        v = 0;
        foreach (tbuf[i]) if (tbuf[i] != 8'h2D) v = v * 10 + int'(tbuf[i] - 8'h30);
        if (tbuf[0] == 8'h2D) v = -v;
        model_temp = v;
        push_ev("T", v);
      end else push_ev("E", 0);
      m_in_t = 0;
      return;
    end
    tbuf.push_back(b);
    if (digits_of(tbuf) < 0) begin
      push_ev("E", 0);
      m_in_t = 0;
      m_flush = 1;
    end
  endfunction

  // Monitor
  always @(negedge clock) begin
    int n;
    logic [7:0] k;
    ev_t e;
    if (reset) begin
      n = int'(music_req) + int'(light_req) + int'(curtain_req) + int'(temp_valid) + int'(err);
      if (n != 0) begin
        check("one_hot_pulses", n, 1);
        k = music_req ? 8'h4D : light_req ? 8'h4C : curtain_req ? 8'h43 : temp_valid ? "T" : "E";
        if (exp_q.size() == 0) check("unexpected_event", k, 8'h00);
        else begin
          e = exp_q.pop_front();
          check("event_kind", k, e.kind);
          if (e.kind == "T") check("temp_req", temp_req, e.val);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) begin rx.rx_valid = 0; @(negedge clock); end
    rx.rx_data  = b;
    rx.rx_valid = 1;
    w = 0;
    while (!rx.rx_ready && w < 10) begin @(negedge clock); w++; end
    if (!rx.rx_ready) begin
      check("rx_ready_timeout", 0, 1);
      rx.rx_valid = 0;
      return;
    end
    @(posedge clock);
    model_byte(b);
    #1 check("char_req", char_req, b);
    @(negedge clock);
    rx.rx_valid = 0;
  endtask

  task automatic send_str(input string s, input int gmax);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, gmax));
  endtask

  task automatic drain();
    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", rx.rx_ready, 0);
    check("rst_pulses", {music_req, light_req, curtain_req, temp_valid, err}, 0);
    check("rst_temp_req", temp_req, 32'd25);
    check("rst_char_req", char_req, 8'h00);
  endtask

  initial begin
    int r, n;
    reset = 0;
    rx.rx_valid = 0;
    rx.rx_data = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_vals();
    reset = 1;
    @(negedge clock);
    check("idle_rx_ready", rx.rx_ready, 1);

    send_str("MLC", 0);
    drain();
    check("char_after_mlc", char_req, 8'h43);
    check("temp_after_mlc", temp_req, 32'd25);

    send_str("T-12", 0);
    send_byte(8'h0A, 0);
    check("commit_rx_ready_low", rx.rx_ready, 0);
    @(negedge clock);
    check("after_commit_rx_ready", rx.rx_ready, 1);
    drain();
    check("temp_minus12", temp_req, 32'hFFFFFFF4);

    send_str("T12345\n", 1);
    drain();
    check("temp_kept_after_overflow", temp_req, 32'hFFFFFFF4);
    send_str("t30", 0);
    send_byte(8'h0D, 0);
    drain();
    check("temp_30", temp_req, 32'd30);

    send_str("T\nTX\nQM", 1);
    send_str("T-\nT-0\n", 0);
    drain();
    check("temp_minus0", temp_req, 32'd0);

    send_byte("T", 1);
    send_byte("2", 2);
    reset = 0;
    model_reset();
    @(negedge clock);
    check_reset_vals();
    check("reset_no_pending", exp_q.size(), 0);
    reset = 1;
    @(negedge clock);
    send_str("T7\n", 2);
    drain();
    check("temp_7", temp_req, 32'd7);

    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        r = $urandom_range(0, 5);
        send_byte(r == 0 ? "M" : r == 1 ? "L" : r == 2 ? "C" : r == 3 ? "m" : r == 4 ? "l" : "c",
                  $urandom_range(0, 2));
      end else if (r <= 6) begin
        send_byte($urandom_range(0, 1) ? "T" : "t", $urandom_range(0, 2));
        if ($urandom_range(0, 2) == 0) send_byte("-", $urandom_range(0, 2));
        n = $urandom_range(0, 6);
        repeat (n) send_byte(8'(8'h30 + $urandom_range(0, 9)), $urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) send_byte("X", 0);
        send_byte($urandom_range(0, 1) ? 8'h0A : 8'h0D, $urandom_range(0, 2));
      end else if (r == 7) send_byte(8'h20, 0);
      else if (r == 8) send_byte(8'($urandom_range(33, 126)), $urandom_range(0, 2));
      else send_byte(8'h0A, 0);
    end
    send_byte(8'h0A, 0);
    drain();
    check("final_temp_req", temp_req, model_temp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
